lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly upstream of the RV32I byte-lane memory. It accepts one load or store request at a time from the core over a valid/ready handshake and drives the memory's write/read address, data, `write_mem` and `funct3` ports. It absorbs the memory's one-cycle registered read latency, returns a held response, and flags illegal or misaligned accesses before they reach memory.

## Interface
- `ADDR_W`, 32, address width of request and memory ports
- `clk` in 1, sole clock
- `rst` in 1, reset; one clock, reset is synchronous and active-high
- `req_valid` in 1, core request valid
- `req_ready` out 1, LSU can accept a request
- `req_we` in 1, 1 = store, 0 = load
- `req_funct3` in 3, RV32I load/store funct3 (size and signedness)
- `req_addr` in ADDR_W, byte address
- `req_wdata` in 32, store data, right-justified
- `rsp_valid` out 1, response valid
- `rsp_ready` in 1, core accepts response
- `rsp_rdata` out 32, load data, already extended by memory; 0 for stores and errors
- `rsp_err` out 1, access rejected, no memory side effect
- `mem_write_mem` out 1, to memory `write_mem`
- `mem_funct3` out 3, to memory `funct3`
- `mem_write_address` out ADDR_W, to memory `write_address`
- `mem_write_data` out 32, to memory `write_data`
- `mem_read_address` out ADDR_W, to memory `read_address`
- `mem_read_data` in 32, from memory `read_data`

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. A request is accepted on `req_valid & req_ready`; `req_we`, `req_funct3`, `req_addr` and `req_wdata` are latched.
- Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Any other value is illegal: go to RESP with `rsp_err`=1 and no memory access.
- Legal accepted request goes to ISSUE. During ISSUE, `mem_funct3` = latched funct3 and both memory addresses = latched address.
  - Store: `mem_write_mem`=1 for exactly this cycle, `mem_write_data` = latched wdata, next state RESP.
  - Load: `mem_write_mem`=0, next state WAIT.
- WAIT: address and funct3 are held unchanged. `mem_read_data` is captured into `rsp_rdata` and the block moves to RESP.
- RESP: `rsp_valid`=1 with `rsp_rdata` and `rsp_err` stable until `rsp_ready`=1, then return to IDLE. A new request is not accepted in the same cycle.
- Outside ISSUE and WAIT, the memory address, funct3 and data outputs hold their last values and `mem_write_mem`=0.
- All outputs except `req_ready` are registered. `req_ready` = (state==IDLE).

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_write_mem`=0, `mem_funct3`=3'b010, both memory addresses 0, `mem_write_data`=0.
- Load accepted at cycle T: ISSUE at T+1 (memory samples address at the end of T+1), WAIT at T+2, `rsp_valid` from T+3.
- Store accepted at T: `mem_write_mem` high during T+1, `rsp_valid` from T+2.
- Error accepted at T: `rsp_valid` with `rsp_err`=1 from T+1.
- Throughput with `rsp_ready` tied high: one load per 4 cycles, one store per 3 cycles.
- Reset mid-operation: state returns to IDLE at the next edge and any pending response is dropped. A store whose ISSUE cycle coincides with `rst`=1 still writes memory, because `mem_write_mem` is already registered high.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, completes as an error (`rsp_err`=1, no memory access, response at T+1).
- Not defined: misaligned addresses are forced to alignment before issue (halfword clears bit 0; word clears bits 1:0) and never flag an error. Illegal funct3 still errors.

## Structure
- `lsu_pkg` holds:
  - state enum `lsu_state_t`
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`
  - functions `f3_legal(we, f3)`, `misaligned(f3, addr)` and `align_addr(f3, addr)`
- No sub-module: single FSM module `lsu`.

## Test plan
- Load word: preload memory 0x10 = 0xDEADBEEF; load f3=010, addr 0x10 at T -> `rsp_valid` at T+3, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Store byte then load: store f3=000, addr 0x21, wdata 0x000000A5 -> `mem_write_mem` pulses one cycle at T+1; then lb at 0x21 -> 0xFFFFFFA5, lbu at 0x21 -> 0x000000A5.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after load response -> `rsp_valid` and `rsp_rdata` stable; `req_ready`=0 throughout; a `req_valid` pulse in that window is ignored.
- Errors: store f3=011 -> `rsp_err`=1 at T+1, memory unchanged. Word load at 0x22 -> err=1 with the macro; without the macro, returns the word at 0x20.
- Reset: assert `rst` during WAIT of a load -> next cycle IDLE, `rsp_valid`=0, `req_ready`=1, no response ever emitted.
- Peripheral read: load word at 0xFFFFFFF8 twice, 24000 cycles apart -> second value = first + 2.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_t  : FSM state encoding
//   F3_*         : RV32I load/store funct3 codes
//   f3_legal     : funct3 legality for a load (we=0) or store (we=1)
//   misaligned   : access size vs. low two address bits
//   align_addr   : low two address bits forced to the access size
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Only the low two address bits matter, which keeps these width-agnostic.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr);
    case (f3[1:0])
      2'b01:   return addr[0];
      2'b10:   return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_addr(input logic [2:0] f3, input logic [1:0] addr);
    case (f3[1:0])
      2'b01:   return {addr[1], 1'b0};
      2'b10:   return 2'b00;
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/lsu.sv
// Load/store unit in front of the RV32I byte-lane memory. Takes one request
// at a time, issues it to memory, absorbs the one-cycle read latency and
// returns a held response. Illegal funct3 is answered with rsp_err and no
// memory access.
//
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses complete as errors
//   undefined : misaligned addresses are silently aligned before issue
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready          request handshake (ready only in IDLE)
//   req_we, req_funct3       store/load select, size and signedness
//   req_addr, req_wdata      byte address, right-justified store data
//   rsp_valid/ready          response handshake
//   rsp_rdata, rsp_err       load data (0 for stores/errors), error flag
//   mem_*                    memory write_mem/funct3/addresses/data, read_data
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_write_mem,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [31:0]       mem_write_data,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [31:0]       mem_read_data
);

  lsu_state_t        r_state, w_state_nxt;
  logic              r_we, w_we_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_mem_write_mem, w_mem_write_mem_nxt;
  logic [2:0]        r_mem_funct3, w_mem_funct3_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nxt;

  logic              w_req_err;
  logic [ADDR_W-1:0] w_req_addr;

  // Request classification and the address actually presented to memory.
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_req_err  = !f3_legal(req_we, req_funct3) ||
                      misaligned(req_funct3, req_addr[1:0]);
  assign w_req_addr = req_addr;
`else
  assign w_req_err  = !f3_legal(req_we, req_funct3);
  assign w_req_addr = {req_addr[ADDR_W-1:2], align_addr(req_funct3, req_addr[1:0])};
`endif

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt         = r_state;
    w_we_nxt            = r_we;
    w_rsp_valid_nxt     = r_rsp_valid;
    w_rsp_rdata_nxt     = r_rsp_rdata;
    w_rsp_err_nxt       = r_rsp_err;
    w_mem_write_mem_nxt = 1'b0;
    w_mem_funct3_nxt    = r_mem_funct3;
    w_mem_addr_nxt      = r_mem_addr;
    w_mem_wdata_nxt     = r_mem_wdata;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_rsp_rdata_nxt = 32'd0;
          if (w_req_err) begin
            w_rsp_err_nxt   = 1'b1;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = ST_RESP;
          end else begin
            // Memory ports are loaded here so they are stable for all of ISSUE.
            w_rsp_err_nxt    = 1'b0;
            w_we_nxt         = req_we;
            w_mem_funct3_nxt = req_funct3;
            w_mem_addr_nxt   = w_req_addr;
            if (req_we) begin
              w_mem_write_mem_nxt = 1'b1;
              w_mem_wdata_nxt     = req_wdata;
            end
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (r_we) begin
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Memory read data is valid one cycle after the ISSUE address.
        w_rsp_rdata_nxt = mem_read_data;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_we            <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= 32'd0;
      r_rsp_err       <= 1'b0;
      r_mem_write_mem <= 1'b0;
      r_mem_funct3    <= F3_W;
      r_mem_addr      <= '0;
      r_mem_wdata     <= 32'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_we            <= w_we_nxt;
      r_rsp_valid     <= w_rsp_valid_nxt;
      r_rsp_rdata     <= w_rsp_rdata_nxt;
      r_rsp_err       <= w_rsp_err_nxt;
      r_mem_write_mem <= w_mem_write_mem_nxt;
      r_mem_funct3    <= w_mem_funct3_nxt;
      r_mem_addr      <= w_mem_addr_nxt;
      r_mem_wdata     <= w_mem_wdata_nxt;
    end
  end

  assign req_ready         = (r_state == ST_IDLE);
  assign rsp_valid         = r_rsp_valid;
  assign rsp_rdata         = r_rsp_rdata;
  assign rsp_err           = r_rsp_err;
  assign mem_write_mem     = r_mem_write_mem;
  assign mem_funct3        = r_mem_funct3;
  assign mem_write_address = r_mem_addr;
  assign mem_read_address  = r_mem_addr;
  assign mem_write_data    = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-lane memory with registered read and a slow tick
// peripheral at the top of the address space, a byte-array reference model
// of the load/store rules, directed cases and a randomized request stream.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address, mem_read_data;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;

  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];

  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: byte lanes, read registered by one clock, tick counter at the top.
  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = {tb_mem[8'(a + 32'd3)], tb_mem[8'(a + 32'd2)], tb_mem[8'(a + 32'd1)], tb_mem[8'(a)]};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_read_address >= 32'hFFFF_FFF0) mem_read_data <= 32'h100 + cyc / 12000;
    else                                   mem_read_data <= mem_rd(mem_read_address, mem_funct3);
    if (mem_write_mem) begin
      for (int i = 0; i < (1 << mem_funct3[1:0]); i++)
        tb_mem[8'(mem_write_address + 32'(i))] = 8'(mem_write_data >> (8 * i));
    end
  end

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      tb_mem[8'(a + 32'(i))]  = 8'(w >> (8 * i));
      ref_mem[8'(a + 32'(i))] = 8'(w >> (8 * i));
    end
  endtask

  // Reference: legality, alignment, byte array update/extract, expected latency.
  function automatic void ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                   output logic [31:0] ea_o, output int lat);
    longint unsigned sz, ea, v;
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz    = 64'd1 << f3[1:0];
    err   = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((64'(a) % sz) != 0) err = 1'b1;
    ea = 64'(a);
`else
    ea = 64'(a) - (64'(a) % sz);
`endif
    ea_o = 32'(ea);
    rd   = 32'd0;
    lat  = err ? 1 : (we ? 2 : 3);
    if (!err && we) begin
      for (longint unsigned i = 0; i < sz; i++)
        ref_mem[int'((ea + i) % 256)] = 8'(wd >> (8 * i));
    end else if (!err) begin
      v = 0;
      for (longint unsigned i = 0; i < sz; i++)
        v += 64'(ref_mem[int'((ea + i) % 256)]) << (8 * i);
      if (!f3[2] && v >= (64'd1 << (8 * sz - 1))) v -= 64'd1 << (8 * sz);
      rd = 32'(v);
    end
  endfunction

  // One request end to end: latency, write pulse, response, backpressure, release.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int bp, input bit chk_data,
                         output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd, e_ea;
    int          e_lat, lat, wm;
    ref_exec(we, f3, a, wd, e_err, e_rd, e_ea, e_lat);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr  = $urandom; req_wdata = $urandom;
    lat = 1; wm = 0;
    while (!rsp_valid && lat < 8) begin
      if (mem_write_mem) begin
        wm++;
        chk("wr_addr", mem_write_address, e_ea);
        chk("wr_data", mem_write_data, wd);
        chk("wr_f3", 32'(mem_funct3), 32'(f3));
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("wr_pulses", 32'(wm), 32'(we && !e_err));
    chk("wm_idle", 32'(mem_write_mem), 32'd0);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    if (chk_data) chk("rsp_rdata", rsp_rdata, e_rd);
    got = rsp_rdata;
    for (int i = 0; i < bp; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = $urandom_range(0, 255); req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, got);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_release", 32'(rsp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got, first;
    logic        we;
    logic [2:0]  f3;
    int          seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_write_mem", 32'(mem_write_mem), 32'd0);
    chk("rst_funct3", 32'(mem_funct3), 32'd2);
    chk("rst_waddr", mem_write_address, 32'd0);
    chk("rst_raddr", mem_read_address, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    rst = 1'b0;

    poke_word(32'h10, 32'hDEAD_BEEF);
    run_req(1'b0, 3'b010, 32'h10, 32'd0, 0, 1'b1, got);
    chk("lw_0x10", got, 32'hDEAD_BEEF);
    run_req(1'b1, 3'b000, 32'h21, 32'h0000_00A5, 0, 1'b1, got);
    run_req(1'b0, 3'b000, 32'h21, 32'd0, 5, 1'b1, got);
    chk("lb_0x21", got, 32'hFFFF_FFA5);
    run_req(1'b0, 3'b100, 32'h21, 32'd0, 0, 1'b1, got);
    chk("lbu_0x21", got, 32'h0000_00A5);

    poke_word(32'h30, 32'h1357_9BDF);
    run_req(1'b1, 3'b011, 32'h30, 32'h1234_5678, 0, 1'b1, got);
    run_req(1'b0, 3'b010, 32'h30, 32'd0, 0, 1'b1, got);
    chk("store_err_no_write", got, 32'h1357_9BDF);

    poke_word(32'h20, 32'h1122_3344);
    run_req(1'b0, 3'b010, 32'h22, 32'd0, 0, 1'b1, got);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_0x22_trap", got, 32'd0);
`else
    chk("lw_0x22_align", got, 32'h1122_3344);
`endif

    // Reset while the load sits in WAIT: no response must follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("rst_mid_no_rsp", 32'(seen), 32'd0);

    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 99) < 85) begin
        f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
        if (!we && f3 == 3'd3) f3 = 3'd4;
        else if (!we && f3 == 3'd4) f3 = 3'd5;
      end else begin
        f3 = 3'($urandom);
      end
      run_req(we, f3, 32'($urandom_range(0, 255)), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1, got);
    end

    // Tick peripheral sampled twice, exactly 24000 cycles apart.
    run_req(1'b0, 3'b010, 32'hFFFF_FFF8, 32'd0, 0, 1'b0, first);
    begin
      int unsigned t0;
      t0 = acc_cyc;
      while (cyc != t0 + 23999) begin
        @(posedge clk); #1;
      end
    end
    run_req(1'b0, 3'b010, 32'hFFFF_FFF8, 32'd0, 0, 1'b0, got);
    chk("periph_tick", got, first + 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
